// File: rtl/tt_mux_pkg.sv
// Shared types and field positions for the project-slot multiplexer.
package tt_mux_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_RESET  = 2'd2,
        ST_ACTIVE = 2'd3
    } state_t;

    localparam int IW_CLK_BIT  = 0;
    localparam int IW_RSTN_BIT = 1;
    localparam int IW_DATA_LSB = 2;

    // LSB position of a slot's field inside a flattened per-slot bus.
    function automatic int ow_slice(input int slot, input int width);
        return slot * width;
    endfunction

endpackage

// File: rtl/tt_mux_rst_timer.sv
// Loadable down-counter timing how long a newly selected slot stays in reset.
module tt_mux_rst_timer
#(
    parameter int RST_HOLD = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    output logic done
);

    localparam int CW = (RST_HOLD > 1) ? $clog2(RST_HOLD) : 1;

    logic [CW-1:0] r_cnt;

    // Loaded with RST_HOLD-1 so the reset phase lasts RST_HOLD cycles; parks at zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (load) begin
            r_cnt <= CW'(RST_HOLD - 1);
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign done = (r_cnt == '0);

endmodule

// File: rtl/tt_slot_mux.sv
// N-slot project multiplexer: routes pad inputs to the selected wrapper and registers its outputs to the pads.
// state | meaning: IDLE no slot enabled | DRAIN old slot off, outputs 0 | RESET new slot held in reset | ACTIVE new slot running
module tt_slot_mux
    import tt_mux_pkg::*;
#(
    parameter int N_SLOTS  = 16,
    parameter int IW_W     = 18,
    parameter int OW_W     = 24,
    parameter int RST_HOLD = 4,
    localparam int SEL_W   = $clog2(N_SLOTS)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    sel_valid,
    input  logic [SEL_W-1:0]        sel_addr,
    output logic                    sel_ready,
    output logic                    sel_err,
    input  logic                    proj_clk,
    input  logic                    pad_rst_n,
    input  logic [IW_W-3:0]         pad_in,
    output logic [OW_W-1:0]         pad_out,
    output logic [N_SLOTS-1:0]      ena,
    output logic [N_SLOTS*IW_W-1:0] iw_bus,
    input  logic [N_SLOTS*OW_W-1:0] ow_bus,
    output logic [SEL_W-1:0]        active_slot,
    output logic                    active_valid
);

    state_t            r_state;
    state_t            w_state_nxt;
    logic [SEL_W-1:0]  r_target;
    logic              r_sel_err;
    logic [OW_W-1:0]   r_pad_out;
    logic              w_accept;
    logic              w_tgt_ok;
    logic              w_slot_on;
    logic              w_tmr_load;
    logic              w_tmr_done;

    assign sel_ready  = (r_state == ST_IDLE) || (r_state == ST_ACTIVE);
    assign w_accept   = sel_valid && sel_ready;
    assign w_tgt_ok   = int'(r_target) < N_SLOTS;
    assign w_slot_on  = (r_state == ST_RESET) || (r_state == ST_ACTIVE);
    assign w_tmr_load = (r_state == ST_DRAIN);

    tt_mux_rst_timer #(
        .RST_HOLD (RST_HOLD)
    ) u_rst_timer (
        .clk  (clk),
        .rst  (rst),
        .load (w_tmr_load),
        .done (w_tmr_done)
    );

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE, ST_ACTIVE: if (w_accept) w_state_nxt = ST_DRAIN;
            ST_DRAIN:           w_state_nxt = w_tgt_ok ? ST_RESET : ST_IDLE;
            ST_RESET:           if (w_tmr_done) w_state_nxt = ST_ACTIVE;
            default:            w_state_nxt = ST_IDLE;
        endcase
    end

    // Leaving ACTIVE blanks pad_out immediately, so the accept cycle already loads zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_target  <= '0;
            r_sel_err <= 1'b0;
            r_pad_out <= '0;
        end else begin
            r_state   <= w_state_nxt;
            if (w_accept) begin
                r_target <= sel_addr;
            end
            r_sel_err <= (r_state == ST_DRAIN) && !w_tgt_ok;
            if ((r_state == ST_ACTIVE) && (w_state_nxt == ST_ACTIVE)) begin
                r_pad_out <= ow_bus[ow_slice(int'(r_target), OW_W) +: OW_W];
            end else begin
                r_pad_out <= '0;
            end
        end
    end

    for (genvar k = 0; k < N_SLOTS; k++) begin : g_slot
        assign ena[k] = w_slot_on && (r_target == SEL_W'(k));
        assign iw_bus[k*IW_W + IW_CLK_BIT]              = ena[k] & proj_clk;
        assign iw_bus[k*IW_W + IW_RSTN_BIT]             = ena[k] & (r_state == ST_ACTIVE) & pad_rst_n;
        assign iw_bus[k*IW_W + IW_DATA_LSB +: IW_W - 2] = pad_in;
    end

    assign sel_err      = r_sel_err;
    assign pad_out      = r_pad_out;
    assign active_slot  = r_target;
    assign active_valid = (r_state == ST_ACTIVE);

endmodule

// File: doc/tt_slot_mux.md
# tt_slot_mux

Parametrised N-slot project multiplexer that sits between the chip pad ring and the per-project wrapper buses. It packs pad inputs into each slot's `iw` bus (`{uio_in, ui_in, rst_n, clk}`) and registers the selected slot's `ow` bus (`{uio_oe, uio_out, uo_out}`) back to the pads. Slot switching is a handshake-driven sequence:

- drain the old slot,
- hold the new slot in reset for a programmable time,
- enable the new slot.

## Interface

Parameters:
- `N_SLOTS`, 16: number of project slots; must be at least 2.
- `IW_W`, 18: per-slot input bus width; bit 0 is clk, bit 1 is rst_n, bits [IW_W-1:2] are pad data.
- `OW_W`, 24: per-slot output bus width.
- `RST_HOLD`, 4: cycles the new slot's rst_n is held low; must be at least 1.
- `SEL_W`: localparam, `$clog2(N_SLOTS)`.

Ports:
- `clk` in 1: system clock. One clock domain.
- `rst` in 1: reset, synchronous, active-high.
- `sel_valid` in 1: slot-switch request.
- `sel_addr` in SEL_W: requested slot.
- `sel_ready` out 1: request can be accepted.
- `sel_err` out 1: one-cycle pulse; the accepted address was ≥ N_SLOTS.
- `proj_clk` in 1: project clock bit, forwarded to the active slot only.
- `pad_rst_n` in 1: pad reset for projects.
- `pad_in` in IW_W-2: `{uio_in, ui_in}` from the pads.
- `pad_out` out OW_W: registered `ow` of the active slot.
- `ena` out N_SLOTS: one-hot or zero; slot enables.
- `iw_bus` out N_SLOTS*IW_W: slot k occupies bits [k*IW_W +: IW_W].
- `ow_bus` in N_SLOTS*OW_W: slot k occupies bits [k*OW_W +: OW_W].
- `active_slot` out SEL_W: current slot index.
- `active_valid` out 1: high only in ACTIVE.

## Operation

States:
- IDLE: no slot enabled.
- DRAIN: old slot disabled, outputs forced to 0.
- RESET: new slot enabled, its rst_n held low.
- ACTIVE: new slot running.

Transitions:
- `sel_ready` = 1 in IDLE and ACTIVE; 0 in DRAIN and RESET.
- Accept happens when `sel_valid && sel_ready`. `sel_addr` is latched into the target register.
- IDLE or ACTIVE, on accept → DRAIN, unconditionally. Re-selecting the current slot still runs the full sequence.
- DRAIN → RESET after 1 cycle, if target < N_SLOTS.
- DRAIN → IDLE after 1 cycle, if target ≥ N_SLOTS. `sel_err` pulses in that DRAIN→IDLE cycle.
- RESET → ACTIVE after RST_HOLD cycles.

Per-slot `iw` bus:
- Data field = `pad_in`, broadcast to all slots.
- clk bit = `proj_clk` for the target slot in RESET/ACTIVE; 0 for all others.
- rst_n bit = 0 in RESET; `pad_rst_n` in ACTIVE; 0 for non-target slots.

Enables and outputs:
- `ena[target]` = 1 in RESET and ACTIVE only. All `ena` bits are 0 in IDLE and DRAIN.
- `pad_out` is registered: in ACTIVE it samples `ow_bus[target]`; in any other state it loads 0.
- `active_slot` = target register. Its value is held (not reset to 0) when `active_valid` = 0, except after `rst`.

## Timing

Reset values:
- After `rst`: state IDLE, `ena` = 0, `pad_out` = 0, `active_slot` = 0.
- `active_valid` = 0, `sel_err` = 0, `sel_ready` = 1.

Switch sequence, with the accept at cycle T:
- T+1: DRAIN.
- T+2 … T+1+RST_HOLD: RESET.
- T+2+RST_HOLD: ACTIVE, `active_valid` = 1.
- First `pad_out` reflecting the new slot appears at T+3+RST_HOLD.

Boundary conditions:
- `pad_out` latency in ACTIVE is 1 cycle from `ow_bus`.
- `sel_valid` while `sel_ready` = 0 is ignored, not queued.
- `rst` asserted mid-sequence: IDLE on the next edge, all outputs return to reset values. `rst` has priority over an accept in the same cycle.
- The RST_HOLD counter reloads on every entry to RESET and never wraps within a sequence.

## Structure

- Package `tt_mux_pkg`:
  - State enum.
  - Field constants `IW_CLK_BIT` = 0, `IW_RSTN_BIT` = 1, `IW_DATA_LSB` = 2.
  - Function `ow_slice`, for slot slicing.
- Sub-module `tt_mux_rst_timer`: loadable down-counter, parameter RST_HOLD, outputs `done`.
- Top level holds the FSM, target register, per-slot `iw` generation loop, and `pad_out` register.

## Test plan

- Reset, then select slot 3 (N_SLOTS=16, RST_HOLD=4), accepted at T:
  - `ena` = 0x0008 from T+2.
  - `iw` slot 3 rst_n bit low for 4 cycles.
  - `active_valid` high at T+6.
  - With `ow_bus[3]` = 0xA5C33C, `pad_out` = 0xA5C33C at T+7.
- In ACTIVE on slot 3, select slot 9:
  - `ena` = 0 and `pad_out` = 0 at T+1.
  - `ena` = 0x0200 from T+2.
  - Slot 3 clk and rst_n bits are 0 throughout.
- With N_SLOTS=12, select address 13:
  - `sel_err` is a single pulse at T+2.
  - State IDLE, `ena` = 0, `sel_ready` = 1.
- Hold `sel_valid` high during RESET with a different address:
  - Ignored; `ena` stays on the original target.
  - Sequence completes unchanged.
- Assert `rst` in the second RESET cycle:
  - Next cycle `ena` = 0, `pad_out` = 0, `active_valid` = 0, `sel_ready` = 1.
- Re-select the current active slot 5:
  - Full DRAIN/RESET sequence runs.
  - Slot 5 rst_n is low for RST_HOLD cycles.
